// File: rtl/decode_control_pipe_if.sv
// Handshake/bundle bus between the IF/ID register, the registered decoder and ID/EX.
// master = producer/consumer side, slave = the decode pipe itself.
`timescale 1ns/1ps
interface decode_control_pipe_if #(
  parameter int PC_WIDTH = 32
);
  logic                IN_VALID;
  logic                IN_READY;
  logic [31:0]         INSTRUCTION;
  logic [PC_WIDTH-1:0] PC_IN;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [PC_WIDTH-1:0] PC_OUT;
  logic                OP1SEL_OUT;
  logic                OP2SEL_OUT;
  logic                REG_WRITE_EN_OUT;
  logic [1:0]          WB_SEL_OUT;
  logic [4:0]          ALUOP_OUT;
  logic [2:0]          BRANCH_JUMP_OUT;
  logic [2:0]          IMM_SEL_OUT;
  logic [3:0]          READ_WRITE_OUT;
  logic                ILLEGAL_OUT;

  modport master (
    output IN_VALID, INSTRUCTION, PC_IN, OUT_READY,
    input  IN_READY, OUT_VALID, PC_OUT, OP1SEL_OUT, OP2SEL_OUT, REG_WRITE_EN_OUT,
           WB_SEL_OUT, ALUOP_OUT, BRANCH_JUMP_OUT, IMM_SEL_OUT, READ_WRITE_OUT, ILLEGAL_OUT
  );

  modport slave (
    input  IN_VALID, INSTRUCTION, PC_IN, OUT_READY,
    output IN_READY, OUT_VALID, PC_OUT, OP1SEL_OUT, OP2SEL_OUT, REG_WRITE_EN_OUT,
           WB_SEL_OUT, ALUOP_OUT, BRANCH_JUMP_OUT, IMM_SEL_OUT, READ_WRITE_OUT, ILLEGAL_OUT
  );
endinterface

// File: rtl/decode_control_pipe.sv
// Registered RV32I(+M) control decoder with a 2-entry skid buffer, flush,
// illegal-instruction flagging and a post-divide issue interlock.
`timescale 1ns/1ps
module decode_control_pipe #(
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int DIV_GAP  = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic FLUSH,
  decode_control_pipe_if.slave bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                op1sel;
    logic                op2sel;
    logic                reg_we;
    logic [1:0]          wb_sel;
    logic [4:0]          aluop;
    logic [2:0]          br_jmp;
    logic [2:0]          imm_sel;
    logic [3:0]          rw;
    logic                illegal;
    logic                is_div;
  } bundle_t;

  localparam bit GAP_EN = ENABLE_M && (DIV_GAP > 0);

  function automatic bundle_t nop_bundle();
    bundle_t b;
    b        = '0;
    b.br_jmp = 3'b010;
    return b;
  endfunction

  bundle_t    main_q, main_d, skid_q, skid_d, dec;
  logic       main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic       in_ready_q, in_ready_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, consume, div_hold, ill;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       unused_bits;

  assign unused_bits = ^{bus.INSTRUCTION[24:15], bus.INSTRUCTION[11:7]};

  always_comb begin
    opc     = bus.INSTRUCTION[6:0];
    f3      = bus.INSTRUCTION[14:12];
    f7      = bus.INSTRUCTION[31:25];
    ill     = 1'b0;
    dec     = nop_bundle();
    dec.pc  = bus.PC_IN;
    case (opc)
      7'b0110111: begin // LUI
        dec.reg_we = 1'b1; dec.wb_sel = 2'b10; dec.imm_sel = 3'b000;
      end
      7'b0010111: begin // AUIPC
        dec.op1sel = 1'b1; dec.op2sel = 1'b1; dec.reg_we = 1'b1; dec.imm_sel = 3'b000;
      end
      7'b1101111: begin // JAL
        dec.op1sel = 1'b1; dec.op2sel = 1'b1; dec.reg_we = 1'b1;
        dec.wb_sel = 2'b11; dec.br_jmp = 3'b011; dec.imm_sel = 3'b001;
      end
      7'b1100111: begin // JALR
        dec.op2sel = 1'b1; dec.reg_we = 1'b1; dec.wb_sel = 2'b11;
        dec.br_jmp = 3'b011; dec.imm_sel = 3'b100;
        if (f3 != 3'b000) ill = 1'b1;
      end
      7'b1100011: begin // branches
        dec.op1sel = 1'b1; dec.op2sel = 1'b1; dec.br_jmp = f3; dec.imm_sel = 3'b011;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      7'b0000011: begin // loads
        dec.op2sel = 1'b1; dec.reg_we = 1'b1; dec.wb_sel = 2'b01; dec.imm_sel = 3'b100;
        case (f3)
          3'b000:  dec.rw = 4'b1000;
          3'b001:  dec.rw = 4'b1001;
          3'b010:  dec.rw = 4'b1010;
          3'b100:  dec.rw = 4'b1100;
          3'b101:  dec.rw = 4'b1101;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin // stores
        dec.op2sel = 1'b1; dec.imm_sel = 3'b010;
        case (f3)
          3'b000:  dec.rw = 4'b1011;
          3'b001:  dec.rw = 4'b1110;
          3'b010:  dec.rw = 4'b1111;
          default: ill = 1'b1;
        endcase
      end
      7'b0010011: begin // OP-IMM; funct7 is only an opcode field for the shifts
        dec.op2sel = 1'b1; dec.reg_we = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.aluop   = {f3, f7[5], 1'b0};
          dec.imm_sel = 3'b101;
          if (!(f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000))) ill = 1'b1;
        end else begin
          dec.aluop   = {f3, 2'b00};
          dec.imm_sel = (f3 == 3'b011) ? 3'b110 : 3'b100;
        end
      end
      7'b0110011: begin // OP / RV32M
        dec.reg_we = 1'b1;
        dec.aluop  = {f3, f7[5], f7[0]};
        if (f7 == 7'b0000001) begin
          if (!ENABLE_M) ill = 1'b1;
          else           dec.is_div = f3[2];
        end else if (f7 == 7'b0100000) begin
          if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
        end else if (f7 != 7'b0000000) begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (bus.INSTRUCTION[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      dec         = nop_bundle();
      dec.pc      = bus.PC_IN;
      dec.illegal = 1'b1;
    end
  end

  assign accept  = bus.IN_VALID & in_ready_q;
  assign consume = main_v_q & bus.OUT_READY;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    if (consume) begin
      if (main_q.is_div) cnt_d = 4'(DIV_GAP);
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
    end
    // in_ready_q low whenever skid is full, so an accept always finds a free slot
    if (accept) begin
      if (!main_v_d) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end
    if (FLUSH) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      cnt_d    = 4'd0;
    end
    // Nothing is taken in behind a buffered divide, so the idle gap after it is never bypassed.
    div_hold   = GAP_EN && ((main_v_d && main_d.is_div) || (skid_v_d && skid_d.is_div));
    in_ready_d = !skid_v_d && (cnt_d == 4'd0) && !div_hold;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_q     <= nop_bundle();
      skid_q     <= nop_bundle();
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      cnt_q      <= 4'd0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.IN_READY         = in_ready_q;
  assign bus.OUT_VALID        = main_v_q;
  assign bus.PC_OUT           = main_q.pc;
  assign bus.OP1SEL_OUT       = main_q.op1sel;
  assign bus.OP2SEL_OUT       = main_q.op2sel;
  assign bus.REG_WRITE_EN_OUT = main_q.reg_we;
  assign bus.WB_SEL_OUT       = main_q.wb_sel;
  assign bus.ALUOP_OUT        = main_q.aluop;
  assign bus.BRANCH_JUMP_OUT  = main_q.br_jmp;
  assign bus.IMM_SEL_OUT      = main_q.imm_sel;
  assign bus.READ_WRITE_OUT   = main_q.rw;
  assign bus.ILLEGAL_OUT      = main_q.illegal;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Scoreboard bench for decode_control_pipe: random + directed instruction streams
// checked against an instruction-level reference decoder.
`timescale 1ns/1ps
module tb_decode_control_pipe;
  localparam int GAP = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic        op1, op2, rwe;
    logic [1:0]  wb;
    logic [4:0]  alu;
    logic [2:0]  bj, imm;
    logic [3:0]  rw;
    logic        ill;
    logic        div;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush0 = 1'b0;
  always #5 clk = ~clk;

  decode_control_pipe_if #(.PC_WIDTH(32)) u ();
  decode_control_pipe_if #(.PC_WIDTH(32)) u0 ();

  decode_control_pipe #(.PC_WIDTH(32), .ENABLE_M(1'b1), .DIV_GAP(GAP)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .bus(u.slave));
  decode_control_pipe #(.PC_WIDTH(32), .ENABLE_M(1'b0), .DIV_GAP(0)) dut0 (
    .CLK(clk), .RESET(rst), .FLUSH(flush0), .bus(u0.slave));

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int ready_mode = 1;
  bit flush_req = 0;
  bit rand_flush = 0;
  int acc_cnt = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference decoder written from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    exp_t e;
    bit bad;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int ld_rw[8] = '{8, 9, 10, -1, 12, 13, -1, -1};
    int st_rw[8] = '{11, 14, 15, -1, -1, -1, -1, -1};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; e.bj = 3'd2; e.pc = pc; bad = 0;
    if (opc == 7'h37) begin e.rwe = 1; e.wb = 2; e.imm = 0; end
    else if (opc == 7'h17) begin e.op1 = 1; e.op2 = 1; e.rwe = 1; e.imm = 0; end
    else if (opc == 7'h6F) begin e.op1 = 1; e.op2 = 1; e.rwe = 1; e.wb = 3; e.bj = 3; e.imm = 1; end
    else if (opc == 7'h67) begin e.op2 = 1; e.rwe = 1; e.wb = 3; e.bj = 3; e.imm = 4; bad = (f3 != 0); end
    else if (opc == 7'h63) begin e.op1 = 1; e.op2 = 1; e.bj = f3; e.imm = 3; bad = (f3 == 2 || f3 == 3); end
    else if (opc == 7'h03) begin
      e.op2 = 1; e.rwe = 1; e.wb = 1; e.imm = 4; bad = (ld_rw[f3] < 0);
      if (!bad) e.rw = 4'(ld_rw[f3]);
    end else if (opc == 7'h23) begin
      e.op2 = 1; e.imm = 2; bad = (st_rw[f3] < 0);
      if (!bad) e.rw = 4'(st_rw[f3]);
    end else if (opc == 7'h13) begin
      e.op2 = 1; e.rwe = 1;
      if (f3 == 1 || f3 == 5) begin
        e.imm = 5; e.alu = 5'(int'(f3) * 4 + int'(ins[30]) * 2);
        bad = !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
      end else begin
        e.imm = (f3 == 3) ? 3'd6 : 3'd4; e.alu = 5'(int'(f3) * 4);
      end
    end else if (opc == 7'h33) begin
      e.rwe = 1; e.alu = 5'(int'(f3) * 4 + int'(ins[30]) * 2 + int'(ins[25]));
      if (f7 == 7'h01) begin bad = !en_m; e.div = en_m && (f3 >= 4); end
      else if (f7 == 7'h20) bad = !(f3 == 0 || f3 == 5);
      else bad = (f7 != 0);
    end else bad = 1;
    if (ins[1:0] != 2'b11) bad = 1;
    if (bad) begin e = '0; e.bj = 3'd2; e.pc = pc; e.ill = 1; end
    return e;
  endfunction

  function automatic logic [52:0] vis(input exp_t e);
    return {e.pc, e.op1, e.op2, e.rwe, e.wb, e.alu, e.bj, e.imm, e.rw, e.ill};
  endfunction

  function automatic logic [52:0] out_m();
    return {u.PC_OUT, u.OP1SEL_OUT, u.OP2SEL_OUT, u.REG_WRITE_EN_OUT, u.WB_SEL_OUT, u.ALUOP_OUT,
            u.BRANCH_JUMP_OUT, u.IMM_SEL_OUT, u.READ_WRITE_OUT, u.ILLEGAL_OUT};
  endfunction

  function automatic logic [52:0] out_0();
    return {u0.PC_OUT, u0.OP1SEL_OUT, u0.OP2SEL_OUT, u0.REG_WRITE_EN_OUT, u0.WB_SEL_OUT, u0.ALUOP_OUT,
            u0.BRANCH_JUMP_OUT, u0.IMM_SEL_OUT, u0.READ_WRITE_OUT, u0.ILLEGAL_OUT};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h21};
    r = $urandom();
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6F;
      3: begin r[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000; end
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;
      7: begin r[6:0] = 7'h13; if (r[13:12] == 2'b01) r[31:25] = f7s[$urandom_range(0, 3)]; end
      8: begin r[6:0] = 7'h33; r[31:25] = f7s[$urandom_range(0, 3)]; end
      9: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      10: ;
      default: begin r[6:0] = 7'h33; r[31:25] = 7'h00; r[1:0] = 2'($urandom_range(0, 2)); end
    endcase
    return r;
  endfunction

  // Consumer side: OUT_READY and FLUSH driven mid-cycle.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       u.OUT_READY = 1'b0;
      1:       u.OUT_READY = 1'b1;
      default: u.OUT_READY = ($urandom_range(0, 3) != 0);
    endcase
    flush = flush_req || (rand_flush && ($urandom_range(0, 80) == 0));
  end

  // Stimulus bookkeeping: record each accepted instruction's expected bundle.
  always @(negedge clk) begin
    #1;
    if (rst || flush) sb.delete();
    else if (u.IN_VALID && u.IN_READY) begin
      sb.push_back(model(u.INSTRUCTION, u.PC_IN, 1'b1));
      acc_cnt++;
    end
  end

  // Monitor: every presented bundle is compared with the head of the scoreboard.
  int cyc = 0;
  int last_div = 0;
  bit div_armed = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && u.OUT_VALID === 1'b1) begin
      if (div_armed) begin
        chk("div_gap", 64'(cyc - last_div >= GAP + 1), 64'd1);
        div_armed = 0;
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got pc %h, expected no output (t=%0t)", u.PC_OUT, $time);
      end else begin
        chk("bundle", 64'(out_m()), 64'(vis(sb[0])));
        if (u.OUT_READY) begin
          e = sb.pop_front();
          if (e.div) begin div_armed = 1; last_div = cyc; end
        end
      end
    end
    if (flush || rst) div_armed = 0;
  end

  task automatic send(input logic [31:0] ins);
    bit got;
    got = 0;
    u.INSTRUCTION = ins; u.PC_IN = pc_ctr; u.IN_VALID = 1'b1;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      got = u.IN_READY;
    end
    chk("send_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    u.IN_VALID = 1'b0;
    pc_ctr += 4;
  endtask

  task automatic check_rst(input string nm);
    chk({nm, "_out_valid"}, 64'(u.OUT_VALID), 64'd0);
    chk({nm, "_in_ready"}, 64'(u.IN_READY), 64'd1);
    chk({nm, "_bundle"}, 64'(out_m()), {11'd0, 32'd0, 3'b000, 2'b00, 5'd0, 3'b010, 3'd0, 4'd0, 1'b0});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    u.IN_VALID = 0; u.INSTRUCTION = 0; u.PC_IN = 0;
    u0.IN_VALID = 0; u0.INSTRUCTION = 0; u0.PC_IN = 0; u0.OUT_READY = 1'b1;
    step(3);
    rst = 0;
    @(negedge clk);
    check_rst("reset");
    chk("m_off_reset_valid", 64'(u0.OUT_VALID), 64'd0);
    @(posedge clk); #1;

    // ADD into an empty block: one cycle of latency
    send(32'h003100B3);
    @(negedge clk);
    chk("latency", 64'(u.OUT_VALID), 64'd1);
    @(posedge clk); #1;

    // LW, SH, BLTU, JAL back-to-back
    send(32'h00012083); send(32'h00311223); send(32'h0020E463); send(32'h010000EF);
    step(3);

    // Stall with IN_VALID held: exactly two accepted, then ordered drain
    ready_mode = 0;
    step(1);
    a0 = acc_cnt;
    fork
      begin send(32'h00100093); send(32'h00200113); send(32'h00300193); send(32'h00400213); end
      begin
        repeat (4) @(negedge clk);
        #2;
        chk("stall_accepts", 64'(acc_cnt - a0), 64'd2);
        chk("stall_in_ready", 64'(u.IN_READY), 64'd0);
        @(posedge clk); #1;
        ready_mode = 1;
      end
    join
    step(4);

    // Divide interlock, then an illegal DIV on the ENABLE_M=0 instance
    send(32'h023140B3); send(32'h003100B3);
    step(8);
    u0.INSTRUCTION = 32'h023140B3; u0.PC_IN = 32'h100; u0.IN_VALID = 1'b1;
    step(1);
    u0.IN_VALID = 1'b0;
    @(negedge clk);
    chk("m_off_valid", 64'(u0.OUT_VALID), 64'd1);
    chk("m_off_div", 64'(out_0()), 64'(vis(model(32'h023140B3, 32'h100, 1'b0))));
    @(posedge clk); #1;

    // Illegal opcode and SRAI with a bad funct7
    send(32'h0000007F); send(32'h42115093);
    step(3);

    // Flush with both slots full
    ready_mode = 0;
    step(1);
    send(32'h00500293); send(32'h00600313);
    u.INSTRUCTION = 32'h00700393; u.PC_IN = pc_ctr; u.IN_VALID = 1'b1; flush_req = 1;
    step(1);
    u.IN_VALID = 1'b0; flush_req = 0;
    @(negedge clk);
    chk("flush2_valid", 64'(u.OUT_VALID), 64'd0);
    chk("flush2_ready", 64'(u.IN_READY), 64'd1);
    @(posedge clk); #1;
    // Flush with main full and a same-cycle acceptance
    send(32'h00800413);
    u.INSTRUCTION = 32'h00900493; u.PC_IN = pc_ctr; u.IN_VALID = 1'b1; flush_req = 1;
    step(1);
    u.IN_VALID = 1'b0; flush_req = 0;
    @(negedge clk);
    chk("flush1_valid", 64'(u.OUT_VALID), 64'd0);
    chk("flush1_ready", 64'(u.IN_READY), 64'd1);
    @(posedge clk); #1;
    ready_mode = 1;
    step(5);

    // Random traffic with random backpressure and occasional flushes
    ready_mode = 2; rand_flush = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
      send(rand_ins());
    end
    rand_flush = 0; ready_mode = 1;
    for (int t = 0; t < 200 && (sb.size() != 0 || u.OUT_VALID); t++) step(1);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    // Reset mid-stream
    ready_mode = 0;
    step(1);
    send(32'h00A00513); send(32'h00B00593);
    rst = 1;
    step(1);
    @(negedge clk);
    check_rst("rst_mid");
    @(posedge clk); #1;
    rst = 0; ready_mode = 1;
    step(1);
    @(negedge clk);
    check_rst("rst_after");
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
